seq_symbol_tx: RTL and testbench

- Generates the 2-bit symbol stream (X1,X0) consumed by the sequence-detector block: the unlock key C,B,B,A,A, or a deliberately corrupted variant.
- Symbol encoding: NONE=00, A=01, B=10, C=11.
- Sits upstream of the detector as a stimulus/driver block, started by a one-cycle request.
- Reports busy and a one-cycle done pulse.

---
 rtl/seq_symbol_tx.sv | 93 +++++++++
 tb/tb_seq_symbol_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_symbol_tx.sv
// seq_symbol_tx: drives the C,B,B,A,A unlock key (or a corrupted C,B,B,A,B) on X1/X0 for the sequence detector
// Ports: clk, reset (async, active-high), start (accepted in IDLE), bad (latched with start),
//        abort (cancels SEND/GAP), X1/X0 registered symbol (NONE=00 A=01 B=10 C=11),
//        busy (symbols + gap), done (one-cycle pulse on normal completion).
// Optional: SEQ_SYMBOL_TX_LOOP_EN adds input loop; loop=1 during DONE restarts the key right after the pulse.
module seq_symbol_tx #(
    parameter int SYM_CYCLES = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef SEQ_SYMBOL_TX_LOOP_EN
    input  logic loop,
`endif
    input  logic start,
    input  logic bad,
    input  logic abort,
    output logic X1,
    output logic X0,
    output logic busy,
    output logic done
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    localparam logic [7:0] SYM_LAST = 8'(SYM_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [7:0] cnt, cnt_n;
    logic       bad_q, bad_n;
    logic [1:0] sym_n;
    logic       loop_en;
`ifdef SEQ_SYMBOL_TX_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        bad_n   = bad_q;
        case (state)
            IDLE: if (start) begin
                state_n = SEND;
                idx_n   = 3'd0;
                cnt_n   = 8'd0;
                bad_n   = bad;
            end
            SEND: if (abort) state_n = IDLE;
            else if (cnt == SYM_LAST) begin
                cnt_n = 8'd0;
                if (idx == 3'd4) state_n = (GAP_CYCLES > 0) ? GAP : DONE;
                else idx_n = idx + 3'd1;
            end else cnt_n = cnt + 8'd1;
            GAP: if (abort) state_n = IDLE;
            else if (cnt == GAP_LAST) begin
                state_n = DONE;
                cnt_n   = 8'd0;
            end else cnt_n = cnt + 8'd1;
            DONE: begin
                state_n = loop_en ? SEND : IDLE;
                idx_n   = 3'd0;
                cnt_n   = 8'd0;
            end
            default: state_n = IDLE;
        endcase
        // outputs are registered from the next-state view so they line up with the state they describe
        sym_n = (state_n != SEND) ? 2'b00 :
                (idx_n == 3'd0)   ? 2'b11 :
                (idx_n <  3'd3)   ? 2'b10 :
                (idx_n == 3'd3)   ? 2'b01 :
                bad_n             ? 2'b10 : 2'b01;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 8'd0;
            bad_q     <= 1'b0;
            {X1, X0}  <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            bad_q     <= bad_n;
            {X1, X0}  <= sym_n;
            busy      <= (state_n == SEND) || (state_n == GAP);
            done      <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_seq_symbol_tx.sv
// tb_seq_symbol_tx: three parameter sets of seq_symbol_tx checked against a timeline model plus directed key patterns
module tb_seq_symbol_tx;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, bad = 1'b0, abort = 1'b0, loop = 1'b0;
    int checks = 0, errors = 0;
    int busy_n [3];
    int done_n [3];
    always #5 clk = ~clk;

    function automatic logic [1:0] key_sym(int k, logic b);
        logic [1:0] key [5];
        key = '{2'b11, 2'b10, 2'b10, 2'b01, b ? 2'b10 : 2'b01};
        return key[k];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : m
        localparam int SS = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int GG = (g == 2) ? 0 : 1;
        logic x1, x0, busy, done;
        logic [3:0] obs, exp;
        logic act = 1'b0, bm = 1'b0;
        int t = 0;
        seq_symbol_tx #(.SYM_CYCLES(SS), .GAP_CYCLES(GG)) dut (
            .clk(clk), .reset(reset),
`ifdef SEQ_SYMBOL_TX_LOOP_EN
            .loop(loop),
`endif
            .start(start), .bad(bad), .abort(abort),
            .X1(x1), .X0(x0), .busy(busy), .done(done));
        assign obs = {x1, x0, busy, done};
        // t counts cycles since the first symbol; the sequence is 5*SS symbol cycles, GG gap cycles, one done cycle
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                act <= 1'b0;
                t   <= 0;
            end else if (act) begin
                if (abort && t < 5 * SS + GG) act <= 1'b0;
                else if (t == 5 * SS + GG) begin
`ifdef SEQ_SYMBOL_TX_LOOP_EN
                    if (loop) t <= 0; else act <= 1'b0;
`else
                    act <= 1'b0;
`endif
                end else t <= t + 1;
            end else if (start) begin
                act <= 1'b1;
                t   <= 0;
                bm  <= bad;
            end
        end
        always_comb begin
            exp = 4'b0000;
            if (act) exp = (t < 5 * SS)      ? {key_sym(t / SS, bm), 2'b10} :
                           (t < 5 * SS + GG) ? 4'b0010 : 4'b0001;
        end
    end

    task automatic cmp(string tag, logic [3:0] o, logic [3:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        @(negedge clk);
        cmp({tag, "/s1g1"}, m[0].obs, m[0].exp);
        cmp({tag, "/s3g1"}, m[1].obs, m[1].exp);
        cmp({tag, "/s2g0"}, m[2].obs, m[2].exp);
        busy_n[0] += int'(m[0].obs[1]); busy_n[1] += int'(m[1].obs[1]); busy_n[2] += int'(m[2].obs[1]);
        done_n[0] += int'(m[0].obs[0]); done_n[1] += int'(m[1].obs[0]); done_n[2] += int'(m[2].obs[0]);
    endtask

    task automatic clr();
        busy_n = '{0, 0, 0};
        done_n = '{0, 0, 0};
    endtask

    task automatic cnt_chk(string tag, int o, int e);
        checks++;
        assert (o == e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    initial begin
        logic [3:0] nom [8];
        logic [3:0] cor [8];
        nom = '{4'b1110, 4'b1010, 4'b1010, 4'b0110, 4'b0110, 4'b0010, 4'b0001, 4'b0000};
        cor = '{4'b1110, 4'b1010, 4'b1010, 4'b0110, 4'b1010, 4'b0010, 4'b0001, 4'b0000};
        clr();
        #1;
        cmp("reset_s1", m[0].obs, 4'b0000);
        cmp("reset_s3", m[1].obs, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc("idle");
            cmp("idle_const", m[0].obs, 4'b0000);
        end
        // nominal key
        start = 1'b1;
        cyc("nom");
        cmp("nom0", m[0].obs, nom[0]);
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cyc("nom");
            cmp($sformatf("nom%0d", i), m[0].obs, nom[i]);
        end
        for (int i = 0; i < 15; i++) cyc("nom_tail");
        // corrupted key; bad changes after start must not matter
        clr();
        start = 1'b1;
        bad = 1'b1;
        cyc("bad");
        cmp("bad0", m[0].obs, cor[0]);
        start = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < 30; i++) begin
            cyc("bad");
            if (i < 8) cmp($sformatf("bad%0d", i), m[0].obs, cor[i]);
        end
        cnt_chk("busy_len_s1g1", busy_n[0], 6);
        cnt_chk("busy_len_s3g1", busy_n[1], 16);
        cnt_chk("busy_len_s2g0", busy_n[2], 10);
        cnt_chk("done_cnt_s3g1", done_n[1], 1);
        // start re-pulsed at the third symbol is ignored
        clr();
        start = 1'b1;
        cyc("rest");
        start = 1'b0;
        cyc("rest");
        start = 1'b1;
        cyc("rest");
        start = 1'b0;
        for (int i = 0; i < 25; i++) cyc("rest");
        cnt_chk("restart_done_s1", done_n[0], 1);
        cnt_chk("restart_done_s3", done_n[1], 1);
        // abort at the second symbol
        clr();
        start = 1'b1;
        cyc("abort");
        start = 1'b0;
        abort = 1'b1;
        cyc("abort");
        cmp("abort_idle", m[0].obs, 4'b0000);
        abort = 1'b0;
        for (int i = 0; i < 20; i++) cyc("abort_tail");
        cnt_chk("abort_no_done", done_n[0] + done_n[1] + done_n[2], 0);
        start = 1'b1;
        cyc("after_abort");
        cmp("after_abort_c", m[0].obs, 4'b1110);
        start = 1'b0;
        for (int i = 0; i < 20; i++) cyc("after_abort");
        // async reset during the third symbol, between edges
        start = 1'b1;
        cyc("areset");
        start = 1'b0;
        cyc("areset");
        cyc("areset");
        cmp("areset_pre", m[0].obs, 4'b1010);
        #2 reset = 1'b1;
        #1;
        cmp("areset_s1", m[0].obs, 4'b0000);
        cmp("areset_s3", m[1].obs, 4'b0000);
        cmp("areset_s2", m[2].obs, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cyc("areset_idle");
`ifdef SEQ_SYMBOL_TX_LOOP_EN
        loop = 1'b1;
        start = 1'b1;
        cyc("loop");
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cyc("loop");
            cmp($sformatf("loop%0d", i), m[0].obs, (i == 7) ? 4'b1110 : nom[i]);
        end
        loop = 1'b0;
        for (int i = 0; i < 30; i++) cyc("loop_tail");
        cmp("loop_end_idle", m[0].obs, 4'b0000);
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 6) == 0;
            bad   = $urandom % 2;
            abort = ($urandom % 40) == 0;
            loop  = ($urandom % 3) == 0;
            cyc("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
